// File: rtl/arbitration_pkg.sv
// rtl/arbitration_pkg.sv - shared types and helpers for the pipeline arbitration unit
package arbitration_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Index width that stays legal for a single-entry space.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// rtl/rr_multi_grant.sv - combinational round-robin picker granting up to NUM_CDB requesters
import arbitration_pkg::*;

module rr_multi_grant #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   last_idx,
  output logic               any_grant
);

  logic [PTR_W-1:0] idx;
  int               granted;

  // Walk from ptr with wrap-around, taking set bits until the channels run out.
  always_comb begin
    grant     = '0;
    last_idx  = '0;
    any_grant = 1'b0;
    idx       = '0;
    granted   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && req[idx] && (granted < NUM_CDB)) begin
        grant[idx] = 1'b1;
        last_idx   = idx;
        any_grant  = 1'b1;
        granted    = granted + 1;
      end
    end
  end

endmodule

// File: rtl/arbitration_unit_multi.sv
// rtl/arbitration_unit_multi.sv - CDB grant arbitration, decode gating, flush sequencing and halts
import arbitration_pkg::*;

module arbitration_unit_multi #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CDB      = 2,
  parameter int ROB_DEPTH    = 16,
  parameter int DECODE_WIDTH = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             broadcastReq,
  input  logic [$clog2(ROB_DEPTH+1)-1:0] robFreeCount,
  input  logic                           queueFull,
  input  logic                           queueEmpty,
  input  logic                           flush,
  output logic [NUM_REQ-1:0]             broadcastGrant,
  output logic                           allowBroadcast,
  output logic                           allowDecode,
  output logic                           IF_halt,
  output logic                           RF_halt,
  output logic                           DecodeROBPipeline_halt,
  output logic                           ROB_halt,
  output logic                           Dispatch_halt,
  output logic                           flushActive,
  output logic [STALL_CNT_W-1:0]         stallCount
);

  localparam int FREE_W = $clog2(ROB_DEPTH + 1);
  localparam int PTR_W  = idx_width(NUM_REQ);
  localparam int FCNT_W = idx_width(FLUSH_CYCLES);

  localparam logic [FREE_W-1:0] DECODE_NEED = FREE_W'(DECODE_WIDTH);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD  = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [FCNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   last_idx;
  logic               any_grant;
  logic               grant_en;
  logic               decode_ok;
  logic               front_halt;

  assign decode_ok = (robFreeCount >= DECODE_NEED) && !queueFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // flush outranks every other transition, including an in-progress flush.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        RUN:   if (!decode_ok) state_d = STALL;
        STALL: if (decode_ok) state_d = RUN;
        FLUSH: begin
          if (flush_cnt_q == '0) state_d = RUN;
          else flush_cnt_d = flush_cnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Every output is qualified by rst so the pipeline is held while reset is high.
  always_comb begin
    front_halt             = rst || (state_q != RUN) || !decode_ok;
    IF_halt                = front_halt;
    RF_halt                = front_halt;
    DecodeROBPipeline_halt = front_halt;
    allowDecode            = !front_halt;
    ROB_halt               = rst || (state_q == FLUSH);
    Dispatch_halt          = rst || (state_q == FLUSH) || queueEmpty;
    flushActive            = !rst && (state_q == FLUSH);
    grant_en               = !rst && (state_q != FLUSH);
  end

  rr_multi_grant #(
    .NUM_REQ (NUM_REQ),
    .NUM_CDB (NUM_CDB),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (broadcastReq),
    .ptr       (rr_ptr),
    .enable    (grant_en),
    .grant     (broadcastGrant),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  assign allowBroadcast = |broadcastGrant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (last_idx == PTR_LAST) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (front_halt && (state_q != FLUSH) && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule
